fetcher: RTL and testbench

Per-warp instruction fetch stage, directly upstream of the decoder. When its warp enters `WARP_FETCH`, it reads one 32-bit instruction from program memory at the warp's PC over a valid/ready handshake. It holds that instruction stable for the decoder through `WARP_DECODE`. A one-entry last-PC buffer skips the memory access on a repeated PC, such as a tight loop or a re-fetch after a stall. Misaligned PCs are trapped and turned into a halt instruction.

---
 rtl/fetcher_pkg.sv | 34 +++
 rtl/fetcher.sv | 110 +++++++++++
 tb/tb_fetcher.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetcher_pkg.sv
// Shared types for the warp pipeline front end.
// Defines warp/fetcher state enums, data and instruction words, and the HALT opcode.
package fetcher_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int OPCODE_BITS = 3;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [DATA_WIDTH-1:0] instruction_t;

    localparam logic [OPCODE_BITS-1:0] OPCODE_HALT = 3'b111;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        FETCHER_IDLE     = 2'd0,
        FETCHER_FETCHING = 2'd1,
        FETCHER_DONE     = 2'd2
    } fetcher_state_t;

    function automatic instruction_t halt_instruction();
        return {OPCODE_HALT, {(DATA_WIDTH-OPCODE_BITS){1'b0}}};
    endfunction

endpackage

// File: rtl/fetcher.sv
// Per-warp instruction fetch: one valid/ready read per miss, a one-entry
// last-PC buffer that short-circuits repeated PCs, and a HALT trap on misaligned PCs.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int INSTR_ADDR_BITS = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  warp_state_t                warp_state,
    input  data_t                      pc,
    output logic                       mem_read_valid,
    output logic [INSTR_ADDR_BITS-1:0] mem_read_address,
    input  logic                       mem_read_ready,
    input  instruction_t               mem_read_data,
    output instruction_t               instruction,
    output fetcher_state_t             fetcher_state,
    output logic                       fetch_error
);

    fetcher_state_t             state_q, state_d;
    logic                       valid_q, valid_d;
    logic [INSTR_ADDR_BITS-1:0] addr_q, addr_d;
    instruction_t               instr_q, instr_d;
    logic                       error_q, error_d;
    logic                       last_valid_q, last_valid_d;
    data_t                      last_pc_q, last_pc_d;
    instruction_t               last_instr_q, last_instr_d;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        error_d      = error_q;
        last_valid_d = last_valid_q;
        last_pc_d    = last_pc_q;
        last_instr_d = last_instr_q;

        case (state_q)
            FETCHER_IDLE: begin
                if (warp_state == WARP_FETCH) begin
                    // Misaligned check first: a buffered PC is always aligned anyway.
                    if (pc[1:0] != 2'b00) begin
                        state_d = FETCHER_DONE;
                        instr_d = halt_instruction();
                        error_d = 1'b1;
                    end else if (last_valid_q && (pc == last_pc_q)) begin
                        state_d = FETCHER_DONE;
                        instr_d = last_instr_q;
                        error_d = 1'b0;
                    end else begin
                        state_d = FETCHER_FETCHING;
                        valid_d = 1'b1;
                        addr_d  = pc[INSTR_ADDR_BITS+1:2];
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready) begin
                    state_d      = FETCHER_DONE;
                    valid_d      = 1'b0;
                    instr_d      = mem_read_data;
                    error_d      = 1'b0;
                    last_valid_d = 1'b1;
                    last_pc_d    = pc;
                    last_instr_d = mem_read_data;
                end
            end
            FETCHER_DONE: begin
                if (warp_state == WARP_DECODE) begin
                    state_d = FETCHER_IDLE;
                end
            end
            default: begin
                state_d = FETCHER_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCHER_IDLE;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            instr_q      <= '0;
            error_q      <= 1'b0;
            last_valid_q <= 1'b0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            error_q      <= error_d;
            last_valid_q <= last_valid_d;
            last_pc_q    <= last_pc_d;
            last_instr_q <= last_instr_d;
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;
    assign fetcher_state    = state_q;
    assign fetch_error      = error_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: miss, buffer hit, misaligned trap, hold, illegal decode, reset mid-fetch.
module tb_fetcher;
    import fetcher_pkg::*;

    localparam int AB = 12;

    logic           clk = 1'b0;
    logic           reset;
    warp_state_t    warp_state;
    data_t          pc;
    logic           mem_read_valid;
    logic [AB-1:0]  mem_read_address;
    logic           mem_read_ready;
    instruction_t   mem_read_data;
    instruction_t   instruction;
    fetcher_state_t fetcher_state;
    logic           fetch_error;

    int checks = 0;
    int errors = 0;

    fetcher #(.INSTR_ADDR_BITS(AB)) dut (
        .clk              (clk),
        .reset            (reset),
        .warp_state       (warp_state),
        .pc               (pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .instruction      (instruction),
        .fetcher_state    (fetcher_state),
        .fetch_error      (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_core(input string tag, input fetcher_state_t st, input logic vld,
                              input instruction_t ins, input logic err);
        check({tag, ".state"}, 32'(fetcher_state), 32'(st));
        check({tag, ".valid"}, 32'(mem_read_valid), 32'(vld));
        check({tag, ".instr"}, instruction, ins);
        check({tag, ".err"}, 32'(fetch_error), 32'(err));
    endtask

    initial begin
        reset          = 1'b1;
        warp_state     = WARP_IDLE;
        pc             = 32'h0;
        mem_read_ready = 1'b0;
        mem_read_data  = 32'h0;
        @(negedge clk);
        step();
        check_core("reset", FETCHER_IDLE, 1'b0, 32'h0, 1'b0);
        check("reset.addr", 32'(mem_read_address), 32'h0);
        reset = 1'b0;

        // Aligned miss, ready three cycles after valid.
        warp_state = WARP_FETCH;
        pc         = 32'h40;
        step();
        check_core("miss.req", FETCHER_FETCHING, 1'b1, 32'h0, 1'b0);
        check("miss.addr", 32'(mem_read_address), 32'h010);
        step();
        check("miss.wait1.valid", 32'(mem_read_valid), 32'h1);
        step();
        check("miss.wait2.state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h2000_1234;
        step();
        mem_read_ready = 1'b0;
        mem_read_data  = 32'hDEAD_BEEF;
        check_core("miss.done", FETCHER_DONE, 1'b0, 32'h2000_1234, 1'b0);
        step();
        check("miss.hold_in_fetch", 32'(fetcher_state), 32'(FETCHER_DONE));

        // Hold through decode while memory ready toggles.
        warp_state     = WARP_DECODE;
        mem_read_ready = 1'b1;
        step();
        check_core("hold.c1", FETCHER_IDLE, 1'b0, 32'h2000_1234, 1'b0);
        mem_read_ready = 1'b0;
        step();
        mem_read_ready = 1'b1;
        check_core("hold.c2", FETCHER_IDLE, 1'b0, 32'h2000_1234, 1'b0);
        step();
        mem_read_ready = 1'b0;
        warp_state     = WARP_IDLE;
        check("hold.c3.valid", 32'(mem_read_valid), 32'h0);

        // Repeat PC hits the buffer: DONE next cycle, no request.
        warp_state = WARP_FETCH;
        pc         = 32'h40;
        step();
        check_core("hit", FETCHER_DONE, 1'b0, 32'h2000_1234, 1'b0);
        warp_state = WARP_DECODE;
        step();
        check("hit.back_idle", 32'(fetcher_state), 32'(FETCHER_IDLE));

        // Misaligned PC traps to HALT.
        warp_state = WARP_FETCH;
        pc         = 32'h42;
        step();
        check_core("misal", FETCHER_DONE, 1'b0, 32'hE000_0000, 1'b1);
        step();
        check("misal.stay_done", 32'(fetcher_state), 32'(FETCHER_DONE));
        warp_state = WARP_DECODE;
        step();
        check_core("misal.idle", FETCHER_IDLE, 1'b0, 32'hE000_0000, 1'b1);

        // Buffer still holds 0x40 after the misaligned fetch.
        warp_state = WARP_FETCH;
        pc         = 32'h40;
        step();
        check_core("hit2", FETCHER_DONE, 1'b0, 32'h2000_1234, 1'b0);
        warp_state = WARP_DECODE;
        step();

        // Miss with address truncation; illegal DECODE while fetching is ignored.
        warp_state = WARP_FETCH;
        pc         = 32'h0001_0080;
        step();
        check_core("trunc.req", FETCHER_FETCHING, 1'b1, 32'h2000_1234, 1'b0);
        check("trunc.addr", 32'(mem_read_address), 32'h020);
        warp_state = WARP_DECODE;
        step();
        check("illegal.state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        check("illegal.valid", 32'(mem_read_valid), 32'h1);
        warp_state     = WARP_FETCH;
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h1111_2222;
        step();
        mem_read_ready = 1'b0;
        check_core("trunc.done", FETCHER_DONE, 1'b0, 32'h1111_2222, 1'b0);
        warp_state = WARP_DECODE;
        step();

        // Reset while fetching; late ready ignored; buffer cleared.
        warp_state = WARP_FETCH;
        pc         = 32'h44;
        step();
        check("rst.pre.state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h5555_AAAA;
        step();
        reset      = 1'b0;
        warp_state = WARP_IDLE;
        check_core("rst.mid", FETCHER_IDLE, 1'b0, 32'h0, 1'b0);
        step();
        mem_read_ready = 1'b0;
        check_core("rst.late_ready", FETCHER_IDLE, 1'b0, 32'h0, 1'b0);
        warp_state = WARP_FETCH;
        pc         = 32'h40;
        step();
        check_core("rst.refetch", FETCHER_FETCHING, 1'b1, 32'h0, 1'b0);
        check("rst.refetch.addr", 32'(mem_read_address), 32'h010);
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h2000_1234;
        step();
        mem_read_ready = 1'b0;
        check_core("rst.refetch.done", FETCHER_DONE, 1'b0, 32'h2000_1234, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
